// File: rtl/risu_mem_arb.sv
// risu_mem_arb
// N-channel memory request arbiter for the RISu64 top level. Merges NCH
// upstream request/response ports onto one downstream memory bus using
// round-robin grant with a single outstanding transaction.
//
// Optional feature macro: RISU_ARB_TIMEOUT_EN
//   When defined, a watchdog ends a stalled BUSY phase after TIMEOUT cycles
//   with an error response (rdata all ones, ch_resp_err set for the owner).
//   When undefined, BUSY waits indefinitely and ch_resp_err is tied to 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ch_req_*            per-channel request fields, channel i at [i*W +: W]
//   ch_req_valid        per-channel request valid
//   ch_resp_rdata       shared response data, qualified by ch_resp_valid
//   ch_resp_valid       one-hot single-cycle response pulse to the owner
//   ch_resp_err         one-hot timeout error flag, coincident with valid
//   mem_req_*           latched downstream request, held while valid
//   mem_resp_rdata/valid downstream response / completion
//   owner               index of the currently granted channel

module risu_mem_arb #(
  parameter int NCH     = 2,
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NCH*AW-1:0]                      ch_req_addr,
  input  logic [NCH*DW-1:0]                      ch_req_wdata,
  input  logic [NCH*(DW/8)-1:0]                  ch_req_wmask,
  input  logic [NCH-1:0]                         ch_req_wen,
  input  logic [NCH-1:0]                         ch_req_valid,
  output logic [DW-1:0]                          ch_resp_rdata,
  output logic [NCH-1:0]                         ch_resp_valid,
  output logic [NCH-1:0]                         ch_resp_err,
  output logic [AW-1:0]                          mem_req_addr,
  output logic [DW-1:0]                          mem_req_wdata,
  output logic [DW/8-1:0]                        mem_req_wmask,
  output logic                                   mem_req_wen,
  output logic                                   mem_req_valid,
  input  logic [DW-1:0]                          mem_resp_rdata,
  input  logic                                   mem_resp_valid,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] owner
);

  localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [OW-1:0]   last;

  logic            grant_found;
  logic [OW-1:0]   grant_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [MW-1:0]   sel_wmask;
  logic            sel_wen;
  int              scan_idx;
  logic [NCH-1:0]  owner_onehot;

`ifdef RISU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   wd_count;
`endif

  // Round-robin scan: start just after the last granted channel and wrap.
  // The request fields of the winner are muxed out here so the FSM only
  // has to latch them. With NCH=1 the scan always lands on channel 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_wmask   = '0;
    sel_wen     = 1'b0;
    scan_idx    = 0;
    for (int k = 1; k <= NCH; k++) begin
      scan_idx = int'(last) + k;
      if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
      if (!grant_found && ch_req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = OW'(scan_idx);
        sel_addr    = ch_req_addr[scan_idx*AW +: AW];
        sel_wdata   = ch_req_wdata[scan_idx*DW +: DW];
        sel_wmask   = ch_req_wmask[scan_idx*MW +: MW];
        sel_wen     = ch_req_wen[scan_idx];
      end
    end
  end

  // One-hot decode of the owner, used to steer the response pulse.
  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      owner_onehot[i] = (owner == OW'(i));
    end
  end

  // Arbitration FSM. Every output is a register updated here; reset drops
  // any in-flight transaction without producing a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last          <= OW'(NCH - 1);
      owner         <= '0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_valid <= 1'b0;
      ch_resp_rdata <= '0;
      ch_resp_valid <= '0;
`ifdef RISU_ARB_TIMEOUT_EN
      ch_resp_err   <= '0;
      wd_count      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            mem_req_addr  <= sel_addr;
            mem_req_wdata <= sel_wdata;
            mem_req_wmask <= sel_wmask;
            mem_req_wen   <= sel_wen;
            mem_req_valid <= 1'b1;
            owner         <= grant_idx;
            last          <= grant_idx;
            state         <= BUSY;
`ifdef RISU_ARB_TIMEOUT_EN
            wd_count      <= '0;
`endif
          end
        end
        BUSY: begin
          // A real response wins over a watchdog expiry in the same cycle.
          if (mem_resp_valid) begin
            ch_resp_rdata <= mem_resp_rdata;
            ch_resp_valid <= owner_onehot;
            mem_req_valid <= 1'b0;
            state         <= RESP;
`ifdef RISU_ARB_TIMEOUT_EN
          end else if (wd_count == CW'(TIMEOUT - 1)) begin
            ch_resp_rdata <= '1;
            ch_resp_valid <= owner_onehot;
            ch_resp_err   <= owner_onehot;
            mem_req_valid <= 1'b0;
            state         <= RESP;
          end else begin
            wd_count      <= wd_count + 1'b1;
`endif
          end
        end
        RESP: begin
          ch_resp_valid <= '0;
`ifdef RISU_ARB_TIMEOUT_EN
          ch_resp_err   <= '0;
`endif
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef RISU_ARB_TIMEOUT_EN
  assign ch_resp_err = '0;
`endif

endmodule

// File: tb/tb_risu_mem_arb.sv
// Testbench for risu_mem_arb (NCH=2, AW=DW=64, TIMEOUT=16).
// Directed scenarios plus a randomized run checked against a
// transaction-level round-robin model.

module tb_risu_mem_arb;

  localparam int NCH = 2;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MW  = DW / 8;
  localparam int TMO = 16;

  logic                 clk;
  logic                 rst;
  logic [NCH*AW-1:0]    ch_req_addr;
  logic [NCH*DW-1:0]    ch_req_wdata;
  logic [NCH*MW-1:0]    ch_req_wmask;
  logic [NCH-1:0]       ch_req_wen;
  logic [NCH-1:0]       ch_req_valid;
  logic [DW-1:0]        ch_resp_rdata;
  logic [NCH-1:0]       ch_resp_valid;
  logic [NCH-1:0]       ch_resp_err;
  logic [AW-1:0]        mem_req_addr;
  logic [DW-1:0]        mem_req_wdata;
  logic [MW-1:0]        mem_req_wmask;
  logic                 mem_req_wen;
  logic                 mem_req_valid;
  logic [DW-1:0]        mem_resp_rdata;
  logic                 mem_resp_valid;
  logic [0:0]           owner;

  int n_tests;
  int n_fail;

  risu_mem_arb #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_req_addr   (ch_req_addr),
    .ch_req_wdata  (ch_req_wdata),
    .ch_req_wmask  (ch_req_wmask),
    .ch_req_wen    (ch_req_wen),
    .ch_req_valid  (ch_req_valid),
    .ch_resp_rdata (ch_resp_rdata),
    .ch_resp_valid (ch_resp_valid),
    .ch_resp_err   (ch_resp_err),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_req_wen   (mem_req_wen),
    .mem_req_valid (mem_req_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_valid(mem_resp_valid),
    .owner         (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one channel's request fields.
  task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m, input logic we, input logic v);
    ch_req_addr[ch*AW +: AW]  = a;
    ch_req_wdata[ch*DW +: DW] = d;
    ch_req_wmask[ch*MW +: MW] = m;
    ch_req_wen[ch]            = we;
    ch_req_valid[ch]          = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    ch_req_addr    = '0;
    ch_req_wdata   = '0;
    ch_req_wmask   = '0;
    ch_req_wen     = '0;
    ch_req_valid   = '0;
    mem_resp_rdata = '0;
    mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait at negedges until mem_req_valid is seen; ok=0 if the budget expires.
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference round-robin choice: first valid channel after lastp, wrapping.
  function automatic int rr_pick(input int lastp, input logic [NCH-1:0] v);
    for (int k = 1; k <= NCH; k++) begin
      if (v[(lastp + k) % NCH]) return (lastp + k) % NCH;
    end
    return -1;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    ch_req_valid = '0;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_req_valid, ch_resp_valid, ch_resp_err, owner} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b required 0", {mem_req_valid, ch_resp_valid, ch_resp_err, owner});
    end
    n_tests++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, ch_resp_rdata} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: addr=%h wdata=%h rdata=%h required 0", mem_req_addr, mem_req_wdata, ch_resp_rdata);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: mem_req_valid=%b required 0", mem_req_valid);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    set_ch(0, 64'h8000_0000, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000 || owner !== 1'b0 || mem_req_wen !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_req: valid=%b addr=%h owner=%0d required 1 80000000 0", mem_req_valid, mem_req_addr, owner);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    n_tests++;
    if (ch_resp_valid !== 2'b01 || ch_resp_rdata !== 64'hDEADBEEF_CAFEF00D || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_resp: rv=%b rdata=%h mrv=%b required 01 deadbeefcafef00d 0", ch_resp_valid, ch_resp_rdata, mem_req_valid);
    end
    mem_resp_valid = 1'b0;
    ch_req_valid   = '0;
    @(negedge clk);
    n_tests++;
    if (ch_resp_valid !== 2'b00 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_after: rv=%b mrv=%b required 00 0", ch_resp_valid, mem_req_valid);
    end
    @(negedge clk);
    n_tests++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_no_regrant: mrv=%b required 0", mem_req_valid);
    end
  endtask

  task automatic test_contention();
    int exp_order [6] = '{0, 1, 0, 1, 0, 1};
    bit ok;
    do_reset();
    set_ch(0, 64'h1000, '0, '0, 1'b0, 1'b1);
    set_ch(1, 64'h2000, '0, '0, 1'b0, 1'b1);
    for (int t = 0; t < 6; t++) begin
      wait_grant(ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("[TB] FAIL contention_timeout: tx %0d never granted", t);
        break;
      end
      if (int'(owner) !== exp_order[t] || mem_req_addr !== 64'(exp_order[t] + 1) * 64'h1000) begin
        n_fail++;
        $display("[TB] FAIL contention_order: tx %0d owner=%0d addr=%h required %0d", t, owner, mem_req_addr, exp_order[t]);
      end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'(t);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      n_tests++;
      if (ch_resp_valid !== 2'(1 << exp_order[t]) || ch_resp_rdata !== 64'(t)) begin
        n_fail++;
        $display("[TB] FAIL contention_resp: tx %0d rv=%b rdata=%h required %b %0d", t, ch_resp_valid, ch_resp_rdata, 2'(1 << exp_order[t]), t);
      end
    end
    ch_req_valid = '0;
  endtask

  task automatic test_write();
    bit ok;
    do_reset();
    set_ch(1, 64'h2000_0040, 64'h11223344_55667788, 8'h0F, 1'b1, 1'b1);
    wait_grant(ok);
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (!ok || owner !== 1'b1 || mem_req_wen !== 1'b1 || mem_req_wmask !== 8'h0F ||
          mem_req_wdata !== 64'h11223344_55667788 || mem_req_addr !== 64'h2000_0040 ||
          mem_req_valid !== 1'b1 || ch_resp_valid !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL write_hold: cyc %0d ok=%0d owner=%0d wen=%b mask=%h wdata=%h addr=%h rv=%b", c, ok, owner, mem_req_wen, mem_req_wmask, mem_req_wdata, mem_req_addr, ch_resp_valid);
      end
      if (c < 4) @(negedge clk);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0BAD_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    ch_req_valid   = '0;
    n_tests++;
    if (ch_resp_valid !== 2'b10 || ch_resp_rdata !== 64'h0BAD_F00D) begin
      n_fail++;
      $display("[TB] FAIL write_resp: rv=%b rdata=%h required 10 0badf00d", ch_resp_valid, ch_resp_rdata);
    end
    @(negedge clk);
    n_tests++;
    if (ch_resp_valid !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL write_single_pulse: rv=%b required 00", ch_resp_valid);
    end
  endtask

  task automatic test_dropped_valid();
    bit ok;
    do_reset();
    set_ch(0, 64'h3000, '0, '0, 1'b0, 1'b1);
    wait_grant(ok);
    ch_req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (!ok || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h3000) begin
      n_fail++;
      $display("[TB] FAIL drop_hold: ok=%0d mrv=%b addr=%h required 1 3000", ok, mem_req_valid, mem_req_addr);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h55;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    n_tests++;
    if (ch_resp_valid !== 2'b01 || ch_resp_rdata !== 64'h55) begin
      n_fail++;
      $display("[TB] FAIL drop_resp: rv=%b rdata=%h required 01 55", ch_resp_valid, ch_resp_rdata);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    bit seen;
    do_reset();
    set_ch(1, 64'h4000, '0, '0, 1'b0, 1'b1);
    wait_grant(ok);
    rst = 1'b0;
    #1;
    n_tests++;
    if (!ok || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_busy_drop: ok=%0d mrv=%b required 0", ok, mem_req_valid);
    end
    ch_req_valid   = '0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hAA;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ch_resp_valid !== 2'b00 || mem_req_valid !== 1'b0) seen = 1'b1;
      mem_resp_valid = 1'b0;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL rst_busy_late_resp: response or request seen, required none");
    end
    set_ch(0, 64'h5000, '0, '0, 1'b0, 1'b1);
    set_ch(1, 64'h6000, '0, '0, 1'b0, 1'b1);
    wait_grant(ok);
    n_tests++;
    if (!ok || owner !== 1'b0 || mem_req_addr !== 64'h5000) begin
      n_fail++;
      $display("[TB] FAIL rst_busy_first_grant: ok=%0d owner=%0d required 0", ok, owner);
    end
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    ch_req_valid   = '0;
    @(negedge clk);
  endtask

`ifdef RISU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bit bad;
    do_reset();
    set_ch(1, 64'h7000, '0, '0, 1'b0, 1'b1);
    wait_grant(ok);
    bad = !ok;
    for (int c = 2; c <= TMO; c++) begin
      @(negedge clk);
      if (mem_req_valid !== 1'b1 || ch_resp_valid !== 2'b00) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("[TB] FAIL timeout_wait: busy phase ended early or never started");
    end
    @(negedge clk);
    ch_req_valid = '0;
    n_tests++;
    if (ch_resp_valid !== 2'b10 || ch_resp_err !== 2'b10 || ch_resp_rdata !== '1 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_resp: rv=%b err=%b rdata=%h required 10 10 all-ones", ch_resp_valid, ch_resp_err, ch_resp_rdata);
    end
    @(negedge clk);
    n_tests++;
    if (ch_resp_err !== 2'b00 || ch_resp_valid !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL timeout_clear: rv=%b err=%b required 00 00", ch_resp_valid, ch_resp_err);
    end
  endtask
`endif

  // Randomized run: requesters change their valid only in the cycle of a
  // response (or when everyone is idle), so the set seen at each grant is
  // known and the model can predict the winner from the round-robin rule.
  task automatic test_random(input int ntx);
    logic [AW-1:0] m_addr  [NCH];
    logic [DW-1:0] m_wdata [NCH];
    logic [MW-1:0] m_wmask [NCH];
    logic          m_wen   [NCH];
    logic [DW-1:0] exp_rdata;
    int  last_m;
    int  exp_own;
    int  phase;
    int  delay;
    int  done;
    int  idle_cyc;
    do_reset();
    last_m  = NCH - 1;
    phase   = 0;
    done    = 0;
    idle_cyc = 0;
    exp_own = 0;
    delay   = 0;
    exp_rdata = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_addr[ch] = '0; m_wdata[ch] = '0; m_wmask[ch] = '0; m_wen[ch] = 1'b0;
    end
    for (int cyc = 0; cyc < 2000 && done < ntx; cyc++) begin
      if (phase == 0 && ch_req_valid == '0) begin
        for (int ch = 0; ch < NCH; ch++) begin
          if ($urandom_range(1, 0) == 1 || ch == NCH - 1 && ch_req_valid == '0) begin
            m_addr[ch]  = {$urandom, $urandom};
            m_wdata[ch] = {$urandom, $urandom};
            m_wmask[ch] = MW'($urandom);
            m_wen[ch]   = 1'($urandom);
            set_ch(ch, m_addr[ch], m_wdata[ch], m_wmask[ch], m_wen[ch], 1'b1);
          end
        end
      end
      @(negedge clk);
      n_tests++;
      if (ch_resp_err !== '0) begin
        n_fail++;
        $display("[TB] FAIL rand_err: err=%b required 0", ch_resp_err);
      end
      case (phase)
        0: begin
          n_tests++;
          if (ch_resp_valid !== '0) begin
            n_fail++;
            $display("[TB] FAIL rand_spurious_resp: rv=%b required 0", ch_resp_valid);
          end
          if (mem_req_valid === 1'b1) begin
            idle_cyc = 0;
            exp_own  = rr_pick(last_m, ch_req_valid);
            last_m   = exp_own;
            n_tests++;
            if (exp_own < 0 || int'(owner) !== exp_own || mem_req_addr !== m_addr[exp_own] ||
                mem_req_wdata !== m_wdata[exp_own] || mem_req_wmask !== m_wmask[exp_own] ||
                mem_req_wen !== m_wen[exp_own]) begin
              n_fail++;
              $display("[TB] FAIL rand_grant: tx %0d owner=%0d addr=%h required owner %0d", done, owner, mem_req_addr, exp_own);
            end
            delay = $urandom_range(3, 0);
            phase = 1;
          end else begin
            idle_cyc++;
            if (idle_cyc > 4) begin
              n_tests++;
              n_fail++;
              $display("[TB] FAIL rand_no_grant: req=%b not granted within budget", ch_req_valid);
              break;
            end
          end
        end
        1: begin
          if (mem_req_valid !== 1'b1 || int'(owner) !== exp_own || mem_req_addr !== m_addr[exp_own]) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL rand_hold: mrv=%b owner=%0d required 1 %0d", mem_req_valid, owner, exp_own);
          end
          if (delay == 0) begin
            exp_rdata      = {$urandom, $urandom};
            mem_resp_rdata = exp_rdata;
            mem_resp_valid = 1'b1;
            phase          = 2;
          end else begin
            delay--;
          end
        end
        default: begin
          mem_resp_valid = 1'b0;
          n_tests++;
          if (ch_resp_valid !== 2'(1 << exp_own) || ch_resp_rdata !== exp_rdata || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rand_resp: tx %0d rv=%b rdata=%h required %b %h", done, ch_resp_valid, ch_resp_rdata, 2'(1 << exp_own), exp_rdata);
          end
          if ($urandom_range(1, 0) == 1) begin
            m_addr[exp_own]  = {$urandom, $urandom};
            m_wdata[exp_own] = {$urandom, $urandom};
            m_wmask[exp_own] = MW'($urandom);
            m_wen[exp_own]   = 1'($urandom);
            set_ch(exp_own, m_addr[exp_own], m_wdata[exp_own], m_wmask[exp_own], m_wen[exp_own], 1'b1);
          end else begin
            ch_req_valid[exp_own] = 1'b0;
          end
          done++;
          phase = 0;
        end
      endcase
    end
    n_tests++;
    if (done < ntx) begin
      n_fail++;
      $display("[TB] FAIL rand_progress: completed %0d required %0d", done, ntx);
    end
    ch_req_valid   = '0;
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    ch_req_addr    = '0;
    ch_req_wdata   = '0;
    ch_req_wmask   = '0;
    ch_req_wen     = '0;
    ch_req_valid   = '0;
    mem_resp_rdata = '0;
    mem_resp_valid = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_dropped_valid();
    test_reset_mid_busy();
`ifdef RISU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
